// File: rtl/problema1_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// One access granted per cycle; read data steered back by a one-cycle response tag.
module problema1_mem_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_W-1:0]      m0_address,
   input  logic [DATA_W/8-1:0]    m0_byteenable,
   input  logic                   m0_read,
   input  logic                   m0_write,
   input  logic [DATA_W-1:0]      m0_writedata,
   output logic                   m0_waitrequest,
   output logic [DATA_W-1:0]      m0_readdata,
   output logic                   m0_readdatavalid,
   input  logic [ADDR_W-1:0]      m1_address,
   input  logic [DATA_W/8-1:0]    m1_byteenable,
   input  logic                   m1_read,
   input  logic                   m1_write,
   input  logic [DATA_W-1:0]      m1_writedata,
   output logic                   m1_waitrequest,
   output logic [DATA_W-1:0]      m1_readdata,
   output logic                   m1_readdatavalid,
   output logic [ADDR_W-1:0]      mem_address,
   output logic [DATA_W/8-1:0]    mem_byteenable,
   output logic                   mem_chipselect,
   output logic                   mem_write,
   output logic [DATA_W-1:0]      mem_writedata,
   output logic                   mem_clken,
   input  logic [DATA_W-1:0]      mem_readdata,
   output logic [STALL_CNT_W-1:0] stall_m0,
   output logic [STALL_CNT_W-1:0] stall_m1
);

   logic                   req0, req1, gnt0, gnt1, acc;
   logic                   prio_q, prio_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   rsp_id_q, rsp_id_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [STALL_CNT_W-1:0] stall0_q, stall0_d, stall1_q, stall1_d;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Nothing is granted while reset is held, so both masters see waitrequest.
   assign gnt1 = ~reset & req1 & (~req0 | prio_q);
   assign gnt0 = ~reset & req0 & ~gnt1;
   assign acc  = gnt0 | gnt1;

   assign m0_waitrequest = ~gnt0;
   assign m1_waitrequest = ~gnt1;

   assign mem_address    = gnt1 ? m1_address : (gnt0 ? m0_address : addr_q);
   assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
   assign mem_write      = gnt1 ? m1_write : (gnt0 & m0_write);
   assign mem_chipselect = acc;
   assign mem_clken      = ~reset;

   // Read data is shared; only the valid strobe goes to the owner.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rsp_valid_q & ~rsp_id_q;
   assign m1_readdatavalid = rsp_valid_q & rsp_id_q;

   assign stall_m0 = stall0_q;
   assign stall_m1 = stall1_q;

   always_comb begin
      prio_d      = prio_q;
      addr_d      = addr_q;
      rsp_valid_d = acc & ~mem_write;
      rsp_id_d    = rsp_id_q;
      stall0_d    = stall0_q;
      stall1_d    = stall1_q;
      if (acc) begin
         prio_d = gnt0;
         addr_d = mem_address;
      end
      if (acc && !mem_write)
         rsp_id_d = gnt1;
      if (req0 && !gnt0 && stall0_q != '1)
         stall0_d = stall0_q + STALL_CNT_W'(1);
      if (req1 && !gnt1 && stall1_q != '1)
         stall1_d = stall1_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q      <= 1'b0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         stall0_q    <= '0;
         stall1_q    <= '0;
      end else begin
         prio_q      <= prio_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         stall0_q    <= stall0_d;
         stall1_q    <= stall1_d;
      end
   end

endmodule
